// File: rtl/serial_link_if.sv
// Serial link host-side bundle: RX FIFO read port, error flags, TX FIFO
// write port, bit strobes and the serial lines.
//   master: host/driver side (drives strobes, sin, reads, writes)
//   slave : serial_link side (drives FIFO status, data and sout)
interface serial_link_if #(
  parameter int unsigned WIDTH = 16
);
  logic             sin_stb;
  logic             sin;
  logic             rx_rd;
  logic             rx_val;
  logic             rx_full;
  logic [WIDTH-1:0] rx_data;
  logic             rx_perr;
  logic             rx_ovf;
  logic             rx_ferr;
  logic             err_clr;
  logic [WIDTH-1:0] tx_data;
  logic             tx_wr;
  logic             tx_rdy;
  logic             sout_stb;
  logic             sout;
  logic             tx_busy;

  modport master (
    output sin_stb, sin, rx_rd, err_clr, tx_data, tx_wr, sout_stb,
    input  rx_val, rx_full, rx_data, rx_perr, rx_ovf, rx_ferr, tx_rdy, sout, tx_busy
  );

  modport slave (
    input  sin_stb, sin, rx_rd, err_clr, tx_data, tx_wr, sout_stb,
    output rx_val, rx_full, rx_data, rx_perr, rx_ovf, rx_ferr, tx_rdy, sout, tx_busy
  );
endinterface

// File: rtl/serial_link.sv
// Framed single-clock serial link: start bit, WIDTH data bits MSB first,
// optional odd parity, stop bit. Bit timing comes from one-cycle strobes.
// RX deserializer feeds a show-ahead FIFO; a show-ahead TX FIFO feeds a
// serializer that sends back-to-back frames without idle gaps.
//   clock, reset : single clock, synchronous active-high reset
//   bus (slave)  : RX read port + sticky errors, TX write port, strobes, sin/sout
module serial_link #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DEPTH  = 8,
  parameter bit          PARITY = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  serial_link_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned BW = $clog2(WIDTH);
  localparam int unsigned EW = WIDTH + 1;

  typedef enum logic [1:0] {R_IDLE, R_DATA, R_PAR, R_STOP} rx_state_e;
  typedef enum logic [2:0] {T_IDLE, T_ARM, T_START, T_DATA, T_PAR, T_STOP} tx_state_e;

  rx_state_e        rx_state_q, rx_state_d;
  logic [BW-1:0]    rx_cnt_q, rx_cnt_d;
  logic [WIDTH-1:0] rx_sh_q, rx_sh_d;
  logic             rx_perr_q, rx_perr_d;
  logic [AW-1:0]    rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic [CW-1:0]    rx_count_q, rx_count_d;
  logic [EW-1:0]    rx_head_q, rx_head_d;
  logic             rx_val_q, rx_val_d, rx_full_q, rx_full_d;
  logic             rx_ovf_q, rx_ovf_d, rx_ferr_q, rx_ferr_d;
  logic [EW-1:0]    rx_mem_q [DEPTH];

  tx_state_e        tx_state_q, tx_state_d;
  logic [BW-1:0]    tx_cnt_q, tx_cnt_d;
  logic [WIDTH-1:0] tx_sh_q, tx_sh_d;
  logic             tx_par_q, tx_par_d;
  logic             tx_nxt_q, tx_nxt_d;
  logic [AW-1:0]    tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
  logic [CW-1:0]    tx_count_q, tx_count_d;
  logic             tx_rdy_q, tx_rdy_d, tx_busy_q, tx_busy_d, sout_q, sout_d;
  logic [WIDTH-1:0] tx_mem_q [DEPTH];

  logic             rx_push, rx_pop, rx_ovf_set, rx_ferr_set;
  logic [EW-1:0]    rx_wdata;
  logic             tx_push, tx_pop, tx_go;
  logic [WIDTH-1:0] tx_head;

  // Receiver: deserializer FSM, RX FIFO bookkeeping and sticky error flags
  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q;
    rx_sh_d     = rx_sh_q;
    rx_perr_d   = rx_perr_q;
    rx_push     = 1'b0;
    rx_ovf_set  = 1'b0;
    rx_ferr_set = 1'b0;
    rx_wdata    = {rx_perr_q, rx_sh_q};

    if (bus.sin_stb) begin
      case (rx_state_q)
        R_IDLE: begin
          if (!bus.sin) begin
            rx_state_d = R_DATA;
            rx_cnt_d   = '0;
            rx_perr_d  = 1'b0;
          end
        end
        R_DATA: begin
          rx_sh_d = {rx_sh_q[WIDTH-2:0], bus.sin};
          if (rx_cnt_q == BW'(WIDTH - 1)) rx_state_d = PARITY ? R_PAR : R_STOP;
          else                            rx_cnt_d   = rx_cnt_q + BW'(1);
        end
        R_PAR: begin
          // Odd parity: the expected bit is the inverse of the data XOR
          rx_perr_d  = (bus.sin == ^rx_sh_q);
          rx_state_d = R_STOP;
        end
        R_STOP: begin
          rx_state_d = R_IDLE;
          if (!bus.sin)                         rx_ferr_set = 1'b1;
          else if (rx_count_q == CW'(DEPTH))    rx_ovf_set  = 1'b1;
          else                                  rx_push     = 1'b1;
        end
        default: rx_state_d = R_IDLE;
      endcase
    end

    rx_pop  = bus.rx_rd && (rx_count_q != '0);
    rx_wp_d = rx_push ? rx_wp_q + AW'(1) : rx_wp_q;
    rx_rp_d = rx_pop  ? rx_rp_q + AW'(1) : rx_rp_q;
    case ({rx_push, rx_pop})
      2'b10:   rx_count_d = rx_count_q + CW'(1);
      2'b01:   rx_count_d = rx_count_q - CW'(1);
      default: rx_count_d = rx_count_q;
    endcase

    // Registered show-ahead head; bypass the write when it lands at the head
    if (rx_count_d == '0)                     rx_head_d = '0;
    else if (rx_push && (rx_wp_q == rx_rp_d)) rx_head_d = rx_wdata;
    else                                      rx_head_d = rx_mem_q[rx_rp_d];

    rx_val_d  = (rx_count_d != '0);
    rx_full_d = (rx_count_d == CW'(DEPTH));
    rx_ovf_d  = rx_ovf_set  | (rx_ovf_q  & ~bus.err_clr);
    rx_ferr_d = rx_ferr_set | (rx_ferr_q & ~bus.err_clr);
  end

  // Transmitter: serializer FSM and TX FIFO bookkeeping; sout is the bit in flight
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_sh_d    = tx_sh_q;
    tx_par_d   = tx_par_q;
    tx_nxt_d   = tx_nxt_q;
    sout_d     = sout_q;
    tx_pop     = 1'b0;
    tx_go      = tx_nxt_q;
    tx_head    = tx_mem_q[tx_rp_q];

    case (tx_state_q)
      T_IDLE: begin
        if (tx_count_q != '0) begin
          tx_pop     = 1'b1;
          tx_sh_d    = tx_head;
          tx_par_d   = ~^tx_head;
          tx_state_d = T_ARM;
        end
      end
      T_ARM: begin
        if (bus.sout_stb) begin
          sout_d     = 1'b0;
          tx_state_d = T_START;
        end
      end
      T_START: begin
        if (bus.sout_stb) begin
          sout_d     = tx_sh_q[WIDTH-1];
          tx_sh_d    = {tx_sh_q[WIDTH-2:0], 1'b0};
          tx_cnt_d   = '0;
          tx_state_d = T_DATA;
        end
      end
      T_DATA: begin
        if (bus.sout_stb) begin
          if (tx_cnt_q == BW'(WIDTH - 1)) begin
            tx_nxt_d = 1'b0;
            if (PARITY) begin
              sout_d     = tx_par_q;
              tx_state_d = T_PAR;
            end else begin
              sout_d     = 1'b1;
              tx_state_d = T_STOP;
            end
          end else begin
            sout_d   = tx_sh_q[WIDTH-1];
            tx_sh_d  = {tx_sh_q[WIDTH-2:0], 1'b0};
            tx_cnt_d = tx_cnt_q + BW'(1);
          end
        end
      end
      T_PAR: begin
        if (bus.sout_stb) begin
          sout_d     = 1'b1;
          tx_nxt_d   = 1'b0;
          tx_state_d = T_STOP;
        end
      end
      T_STOP: begin
        // Prefetch the next word while the stop bit is on the line
        if (!tx_nxt_q && (tx_count_q != '0)) begin
          tx_pop   = 1'b1;
          tx_sh_d  = tx_head;
          tx_par_d = ~^tx_head;
          tx_nxt_d = 1'b1;
          tx_go    = 1'b1;
        end
        if (bus.sout_stb) begin
          tx_nxt_d = 1'b0;
          if (tx_go) begin
            sout_d     = 1'b0;
            tx_state_d = T_START;
          end else begin
            tx_state_d = T_IDLE;
          end
        end
      end
      default: tx_state_d = T_IDLE;
    endcase

    tx_push = bus.tx_wr && (tx_count_q != CW'(DEPTH));
    tx_wp_d = tx_push ? tx_wp_q + AW'(1) : tx_wp_q;
    tx_rp_d = tx_pop  ? tx_rp_q + AW'(1) : tx_rp_q;
    case ({tx_push, tx_pop})
      2'b10:   tx_count_d = tx_count_q + CW'(1);
      2'b01:   tx_count_d = tx_count_q - CW'(1);
      default: tx_count_d = tx_count_q;
    endcase

    tx_rdy_d  = (tx_count_d != CW'(DEPTH));
    tx_busy_d = (tx_state_d != T_IDLE) || (tx_count_d != '0);
  end

  // State and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_state_q <= R_IDLE;
      rx_cnt_q   <= '0;
      rx_sh_q    <= '0;
      rx_perr_q  <= 1'b0;
      rx_wp_q    <= '0;
      rx_rp_q    <= '0;
      rx_count_q <= '0;
      rx_head_q  <= '0;
      rx_val_q   <= 1'b0;
      rx_full_q  <= 1'b0;
      rx_ovf_q   <= 1'b0;
      rx_ferr_q  <= 1'b0;
      tx_state_q <= T_IDLE;
      tx_cnt_q   <= '0;
      tx_sh_q    <= '0;
      tx_par_q   <= 1'b0;
      tx_nxt_q   <= 1'b0;
      tx_wp_q    <= '0;
      tx_rp_q    <= '0;
      tx_count_q <= '0;
      tx_rdy_q   <= 1'b1;
      tx_busy_q  <= 1'b0;
      sout_q     <= 1'b1;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_sh_q    <= rx_sh_d;
      rx_perr_q  <= rx_perr_d;
      rx_wp_q    <= rx_wp_d;
      rx_rp_q    <= rx_rp_d;
      rx_count_q <= rx_count_d;
      rx_head_q  <= rx_head_d;
      rx_val_q   <= rx_val_d;
      rx_full_q  <= rx_full_d;
      rx_ovf_q   <= rx_ovf_d;
      rx_ferr_q  <= rx_ferr_d;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_sh_q    <= tx_sh_d;
      tx_par_q   <= tx_par_d;
      tx_nxt_q   <= tx_nxt_d;
      tx_wp_q    <= tx_wp_d;
      tx_rp_q    <= tx_rp_d;
      tx_count_q <= tx_count_d;
      tx_rdy_q   <= tx_rdy_d;
      tx_busy_q  <= tx_busy_d;
      sout_q     <= sout_d;
    end
  end

  // FIFO storage; contents need no reset since the pointers gate them
  always_ff @(posedge clock) begin
    if (rx_push && !reset) rx_mem_q[rx_wp_q] <= rx_wdata;
    if (tx_push && !reset) tx_mem_q[tx_wp_q] <= bus.tx_data;
  end

  assign bus.rx_val  = rx_val_q;
  assign bus.rx_full = rx_full_q;
  assign bus.rx_data = rx_head_q[WIDTH-1:0];
  assign bus.rx_perr = rx_head_q[WIDTH];
  assign bus.rx_ovf  = rx_ovf_q;
  assign bus.rx_ferr = rx_ferr_q;
  assign bus.tx_rdy  = tx_rdy_q;
  assign bus.tx_busy = tx_busy_q;
  assign bus.sout    = sout_q;

endmodule

// File: tb/tb_serial_link.sv
// Randomized bench for serial_link (WIDTH=16, DEPTH=8, PARITY=1) with a
// frame-level reference model: expected line bits are built from the frame
// definition and received words are tracked in a queue.
`timescale 1ns/1ps
module tb_serial_link;
  localparam int unsigned WIDTH = 16;
  localparam int unsigned DEPTH = 8;

  typedef bit bitq_t[$];

  logic clock = 1'b0;
  logic reset;
  logic loop;
  logic sin_drv;
  logic drain;

  int n_checks = 0;
  int n_errors = 0;

  bit          obs[$];   // sout value after every sout_stb cycle
  logic [16:0] got[$];   // {perr, data} words drained from RX
  logic [16:0] rxq[$];   // model of RX FIFO contents

  serial_link_if #(.WIDTH(WIDTH)) bus ();

  assign bus.sin = loop ? bus.sout : sin_drv;

  serial_link #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PARITY(1'b1)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    n_checks++;
    if (got_v !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got_v, exp_v);
    end
  endtask

  // One clock; log sout after strobe cycles and optionally drain RX words
  task automatic cyc();
    bit was;
    was = bus.sout_stb;
    @(posedge clock);
    #1;
    if (was) obs.push_back(bus.sout);
    if (drain) begin
      if (bus.rx_rd) bus.rx_rd = 1'b0;
      else if (bus.rx_val) begin
        got.push_back({bus.rx_perr, bus.rx_data});
        bus.rx_rd = 1'b1;
      end
    end
  endtask

  // Frame from the definition: start, data MSB first, odd parity, stop
  function automatic bitq_t mk_frame(input logic [15:0] w, input bit bad_par, input bit stop);
    bitq_t f;
    int ones;
    ones = 0;
    f.push_back(1'b0);
    for (int i = 15; i >= 0; i--) begin
      f.push_back(w[i]);
      ones += int'(w[i]);
    end
    f.push_back(((ones % 2) == 0) ^ bad_par);
    f.push_back(stop);
    return f;
  endfunction

  task automatic strobes(input int n, input int per);
    for (int s = 0; s < n; s++) begin
      for (int c = 0; c < per; c++) begin
        bus.sout_stb = (c == per - 1);
        bus.sin_stb  = (c == per - 1);
        cyc();
      end
    end
    bus.sout_stb = 1'b0;
    bus.sin_stb  = 1'b0;
  endtask

  task automatic send_rx(input bitq_t f, input int per);
    foreach (f[i]) begin
      sin_drv = f[i];
      for (int c = 0; c < per; c++) begin
        bus.sin_stb = (c == per - 1);
        cyc();
      end
    end
    bus.sin_stb = 1'b0;
    sin_drv     = 1'b1;
  endtask

  // Observed line must match the expected bits, then stay idle-high
  task automatic cmp_stream(input string tag, input bitq_t exp);
    int nerr;
    bit e;
    nerr = 0;
    foreach (obs[i]) begin
      e = (i < exp.size()) ? exp[i] : 1'b1;
      if (obs[i] != e) nerr++;
    end
    check(tag, 32'(nerr), 32'(0));
    check({tag, "_len"}, 32'(obs.size() >= exp.size()), 32'(1));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rx_val"},  32'(bus.rx_val),  32'(0));
    check({tag, "_rx_full"}, 32'(bus.rx_full), 32'(0));
    check({tag, "_rx_data"}, 32'(bus.rx_data), 32'(0));
    check({tag, "_rx_perr"}, 32'(bus.rx_perr), 32'(0));
    check({tag, "_rx_ovf"},  32'(bus.rx_ovf),  32'(0));
    check({tag, "_rx_ferr"}, 32'(bus.rx_ferr), 32'(0));
    check({tag, "_tx_rdy"},  32'(bus.tx_rdy),  32'(1));
    check({tag, "_sout"},    32'(bus.sout),    32'(1));
    check({tag, "_tx_busy"}, 32'(bus.tx_busy), 32'(0));
  endtask

  task automatic do_reset();
    bus.sin_stb = 1'b0; bus.sout_stb = 1'b0; bus.rx_rd = 1'b0;
    bus.err_clr = 1'b0; bus.tx_wr = 1'b0;
    reset = 1'b1;
    cyc(); cyc();
    reset = 1'b0;
  endtask

  task automatic write_tx(input logic [15:0] w);
    bus.tx_data = w;
    bus.tx_wr   = 1'b1;
    cyc();
    bus.tx_wr   = 1'b0;
  endtask

  function automatic logic [16:0] got_at(input int i);
    return (i < got.size()) ? got[i] : 17'h1ffff;
  endfunction

  initial begin
    logic [15:0] w [10];
    logic [15:0] rw;
    logic [16:0] e;
    bit          bad;
    bit          eovf;
    int          per;
    bitq_t       exp;
    bitq_t       fr;
    bitq_t       idle1;

    loop = 1'b0; sin_drv = 1'b1; drain = 1'b0;
    bus.tx_data = '0;
    do_reset();
    check_reset_vals("rst");

    // Loopback of the reference word, strobes every 4 clocks
    loop = 1'b1;
    write_tx(16'hA5C3);
    cyc();
    obs.delete(); got.delete();
    drain = 1'b1;
    strobes(24, 4);
    repeat (4) cyc();
    cmp_stream("lb_stream", mk_frame(16'hA5C3, 1'b0, 1'b1));
    check("lb_nwords", 32'(got.size()), 32'(1));
    check("lb_word", 32'(got_at(0)), 32'({1'b0, 16'hA5C3}));
    check("lb_tx_busy", 32'(bus.tx_busy), 32'(0));
    drain = 1'b0;

    // TX FIFO fill with strobes held off: 8 queued + 1 armed
    do_reset();
    loop = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      w[k-1] = 16'($urandom);
      write_tx(w[k-1]);
      check($sformatf("fill_rdy_%0d", k), 32'(bus.tx_rdy), 32'(k < 9));
    end
    check("fill_busy", 32'(bus.tx_busy), 32'(1));
    obs.delete(); got.delete();
    drain = 1'b1;
    per = $urandom_range(1, 5);
    strobes(9 * 19 + 4, per);
    repeat (10) cyc();
    exp.delete();
    for (int k = 0; k < 9; k++) begin
      fr = mk_frame(w[k], 1'b0, 1'b1);
      foreach (fr[i]) exp.push_back(fr[i]);
    end
    cmp_stream("b2b_stream", exp);
    check("b2b_nwords", 32'(got.size()), 32'(9));
    for (int k = 0; k < 9; k++)
      check($sformatf("b2b_word_%0d", k), 32'(got_at(k)), 32'({1'b0, w[k]}));
    check("b2b_ovf", 32'(bus.rx_ovf), 32'(0));
    check("b2b_idle", 32'(bus.tx_busy), 32'(0));
    drain = 1'b0;

    // RX overflow: 9 frames, no reads, random parity corruption
    do_reset();
    loop = 1'b0;
    rxq.delete();
    eovf = 1'b0;
    for (int f = 0; f < 9; f++) begin
      rw  = 16'($urandom);
      bad = 1'($urandom_range(0, 1));
      per = $urandom_range(1, 4);
      send_rx(mk_frame(rw, bad, 1'b1), per);
      if (rxq.size() < DEPTH) rxq.push_back({bad, rw});
      else eovf = 1'b1;
      check($sformatf("ovf_full_%0d", f), 32'(bus.rx_full), 32'(rxq.size() == DEPTH));
      check($sformatf("ovf_flag_%0d", f), 32'(bus.rx_ovf), 32'(eovf));
    end
    for (int i = 0; i < 8; i++) begin
      e = (rxq.size() > 0) ? rxq.pop_front() : 17'h0;
      check($sformatf("ovf_rd_data_%0d", i), 32'(bus.rx_data), 32'(e[15:0]));
      check($sformatf("ovf_rd_perr_%0d", i), 32'(bus.rx_perr), 32'(e[16]));
      bus.rx_rd = 1'b1;
      cyc();
    end
    bus.rx_rd = 1'b0;
    check("ovf_empty_val", 32'(bus.rx_val), 32'(0));
    check("ovf_empty_data", 32'(bus.rx_data), 32'(0));
    check("ovf_still_set", 32'(bus.rx_ovf), 32'(1));
    bus.err_clr = 1'b1;
    cyc();
    bus.err_clr = 1'b0;
    check("ovf_cleared", 32'(bus.rx_ovf), 32'(0));

    // Framing error followed by one idle bit and a good frame
    send_rx(mk_frame(16'h1234, 1'b0, 1'b0), 3);
    check("ferr_set", 32'(bus.rx_ferr), 32'(1));
    check("ferr_dropped", 32'(bus.rx_val), 32'(0));
    idle1.delete(); idle1.push_back(1'b1);
    send_rx(idle1, 3);
    send_rx(mk_frame(16'h5678, 1'b0, 1'b1), 3);
    check("ferr_next_val", 32'(bus.rx_val), 32'(1));
    check("ferr_next_data", 32'(bus.rx_data), 32'(16'h5678));
    bus.rx_rd = 1'b1; cyc(); bus.rx_rd = 1'b0;
    check("ferr_only_one", 32'(bus.rx_val), 32'(0));
    bus.err_clr = 1'b1; cyc(); bus.err_clr = 1'b0;
    check("ferr_cleared", 32'(bus.rx_ferr), 32'(0));

    // Inverted parity bit
    send_rx(mk_frame(16'h0001, 1'b1, 1'b1), 2);
    check("perr_val", 32'(bus.rx_val), 32'(1));
    check("perr_data", 32'(bus.rx_data), 32'(16'h0001));
    check("perr_flag", 32'(bus.rx_perr), 32'(1));
    bus.rx_rd = 1'b1; cyc(); bus.rx_rd = 1'b0;

    // Reset during data bit 7 of a loopback frame, then a clean frame
    loop = 1'b1;
    rw = 16'($urandom);
    write_tx(rw);
    cyc();
    strobes(9, 4);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check_reset_vals("midrst");
    rw = 16'($urandom);
    write_tx(rw);
    cyc();
    obs.delete(); got.delete();
    drain = 1'b1;
    strobes(24, 4);
    repeat (4) cyc();
    cmp_stream("postrst_stream", mk_frame(rw, 1'b0, 1'b1));
    check("postrst_nwords", 32'(got.size()), 32'(1));
    check("postrst_word", 32'(got_at(0)), 32'({1'b0, rw}));
    drain = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
